// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode 7-segment scan driver with frame-coherent snapshot, anti-ghost blanking and DP half-second flag.
// Optional per-digit blinking is built only when the macro FND_BLINK_EN is defined.
module fnd_scan_controller #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_HZ     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mode,
    input  logic [6:0]            msec,
    input  logic [5:0]            sec,
    input  logic [5:0]            min,
    input  logic [4:0]            hour,
    input  logic [NUM_DIGITS-1:0] i_blink_mask,
    output logic [7:0]            fnd_data,
    output logic [NUM_DIGITS-1:0] fnd_com
);
    localparam int TP    = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W = (TP > 1) ? $clog2(TP) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (NUM_DIGITS != 4 && NUM_DIGITS != 8) begin : g_bad_digits
            $error("fnd_scan_controller: NUM_DIGITS must be 4 or 8");
        end
    endgenerate

    function automatic logic [7:0] split_bcd(input logic [6:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = 4'(v % 7'd10);
        tens = 4'((v / 7'd10) % 7'd10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    logic [CNT_W-1:0]      presc_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  started_r;
    logic                  mode_r;
    logic [6:0]            msec_r;
    logic [5:0]            sec_r;
    logic [5:0]            min_r;
    logic [4:0]            hour_r;
    logic [7:0]            fnd_data_r;
    logic [NUM_DIGITS-1:0] fnd_com_r;

    logic                  tick_s;
    logic                  wrap_s;
    logic [2:0]            idx3_s;
    logic [7:0]            ms_bcd_s;
    logic [7:0]            sec_bcd_s;
    logic [7:0]            min_bcd_s;
    logic [7:0]            hr_bcd_s;
    logic [3:0]            digit_s;
    logic [7:0]            seg_s;
    logic                  dp_on_s;
    logic                  blank_digit_s;
    logic [7:0]            data_nxt_s;
    logic [NUM_DIGITS-1:0] com_nxt_s;

    // The first tick after reset is treated as a frame wrap so scanning starts at idx 0 with a fresh snapshot
    assign tick_s = (presc_r == CNT_W'(TP - 1));
    assign wrap_s = tick_s && (!started_r || (idx_r == IDX_W'(NUM_DIGITS - 1)));
    assign idx3_s = 3'(idx_r);

    // Prescaler, which is also the slot-cycle count used for blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {CNT_W{1'b0}};
        end else begin
            presc_r <= presc_r + CNT_W'(1);
        end
    end

    // Digit index and frame-coherent input snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r     <= {IDX_W{1'b0}};
            started_r <= 1'b0;
            mode_r    <= 1'b0;
            msec_r    <= 7'd0;
            sec_r     <= 6'd0;
            min_r     <= 6'd0;
            hour_r    <= 5'd0;
        end else if (wrap_s) begin
            idx_r     <= {IDX_W{1'b0}};
            started_r <= 1'b1;
            mode_r    <= i_mode;
            msec_r    <= msec;
            sec_r     <= sec;
            min_r     <= min;
            hour_r    <= hour;
        end else if (tick_s) begin
            idx_r     <= idx_r + IDX_W'(1);
        end
    end

    assign ms_bcd_s  = split_bcd(msec_r);
    assign sec_bcd_s = split_bcd({1'b0, sec_r});
    assign min_bcd_s = split_bcd({1'b0, min_r});
    assign hr_bcd_s  = split_bcd({2'b00, hour_r});

    generate
        if (NUM_DIGITS == 8) begin : g_map8
            logic mode_unused_s;
            assign mode_unused_s = mode_r;
            // Eight-digit map: hour.min.sec.msec, LSD at idx 0
            always_comb begin
                case (idx3_s)
                    3'd0:    digit_s = ms_bcd_s[3:0];
                    3'd1:    digit_s = ms_bcd_s[7:4];
                    3'd2:    digit_s = sec_bcd_s[3:0];
                    3'd3:    digit_s = sec_bcd_s[7:4];
                    3'd4:    digit_s = min_bcd_s[3:0];
                    3'd5:    digit_s = min_bcd_s[7:4];
                    3'd6:    digit_s = hr_bcd_s[3:0];
                    3'd7:    digit_s = hr_bcd_s[7:4];
                    default: digit_s = 4'hF;
                endcase
            end
        end else begin : g_map4
            // Four-digit map: page chosen by the snapshotted mode
            always_comb begin
                case ({mode_r, idx3_s})
                    4'b0_000: digit_s = ms_bcd_s[3:0];
                    4'b0_001: digit_s = ms_bcd_s[7:4];
                    4'b0_010: digit_s = sec_bcd_s[3:0];
                    4'b0_011: digit_s = sec_bcd_s[7:4];
                    4'b1_000: digit_s = min_bcd_s[3:0];
                    4'b1_001: digit_s = min_bcd_s[7:4];
                    4'b1_010: digit_s = hr_bcd_s[3:0];
                    4'b1_011: digit_s = hr_bcd_s[7:4];
                    default:  digit_s = 4'hF;
                endcase
            end
        end
    endgenerate

    assign seg_s   = seg_code(digit_s);
    assign dp_on_s = (msec_r >= 7'd50) &&
                     ((idx3_s == 3'd2) || (idx3_s == 3'd4) || (idx3_s == 3'd6));

`ifdef FND_BLINK_EN
    localparam int BLINK_TICKS = SCAN_HZ / (2 * BLINK_HZ);
    localparam int BC_W        = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    generate
        if (BLINK_TICKS < 1) begin : g_bad_blink
            $error("fnd_scan_controller: SCAN_HZ/(2*BLINK_HZ) must be >= 1");
        end
    endgenerate

    logic [BC_W-1:0]       blink_cnt_r;
    logic                  blink_off_r;
    logic [NUM_DIGITS-1:0] mask_r;

    // Blink phase: toggles every BLINK_TICKS scan ticks, starts visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r <= {BC_W{1'b0}};
            blink_off_r <= 1'b0;
        end else if (tick_s) begin
            if (blink_cnt_r == BC_W'(BLINK_TICKS - 1)) begin
                blink_cnt_r <= {BC_W{1'b0}};
                blink_off_r <= ~blink_off_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BC_W'(1);
            end
        end
    end

    // Blink mask travels with the frame snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r <= {NUM_DIGITS{1'b0}};
        end else if (wrap_s) begin
            mask_r <= i_blink_mask;
        end
    end

    assign blank_digit_s = blink_off_r && mask_r[idx_r];
`else
    logic blink_unused_s;
    assign blink_unused_s = ^i_blink_mask;
    assign blank_digit_s  = 1'b0;
`endif

    // Next output values; digit enable is held off during the dead time at the start of each slot
    always_comb begin
        com_nxt_s  = {NUM_DIGITS{1'b1}};
        data_nxt_s = 8'hFF;
        if (!started_r) begin
            com_nxt_s  = {NUM_DIGITS{1'b1}};
            data_nxt_s = 8'hFF;
        end else begin
            if (blank_digit_s) begin
                data_nxt_s = 8'hFF;
            end else begin
                data_nxt_s = {~dp_on_s, seg_s[6:0]};
            end
            if ((BLANK_CYCLES > 0) && (presc_r < CNT_W'(BLANK_CYCLES))) begin
                com_nxt_s = {NUM_DIGITS{1'b1}};
            end else begin
                com_nxt_s = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r);
            end
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_data_r <= 8'hFF;
            fnd_com_r  <= {NUM_DIGITS{1'b1}};
        end else begin
            fnd_data_r <= data_nxt_s;
            fnd_com_r  <= com_nxt_s;
        end
    end

    assign fnd_data = fnd_data_r;
    assign fnd_com  = fnd_com_r;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: a 4-digit and an 8-digit instance (TP=10, blank=2) driven side by side.
module tb_fnd_scan_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       mode4;
    logic [6:0] msec4;
    logic [5:0] sec4;
    logic [5:0] min4;
    logic [4:0] hour4;
    logic [7:0] data4;
    logic [3:0] com4;
    logic [6:0] ms8;
    logic [5:0] s8;
    logic [5:0] m8;
    logic [4:0] h8;
    logic [7:0] data8;
    logic [7:0] com8;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    logic [7:0] exp4 [16];
    logic [7:0] exp8 [16];
    logic [3:0] e4;
    logic [7:0] e8;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .CLK_FREQ(100), .SCAN_HZ(10), .NUM_DIGITS(4), .BLANK_CYCLES(2), .BLINK_HZ(1)
    ) u_dut4 (
        .clk(clk), .rst(rst), .i_mode(mode4), .msec(msec4), .sec(sec4), .min(min4),
        .hour(hour4), .i_blink_mask(4'b0000), .fnd_data(data4), .fnd_com(com4)
    );

    fnd_scan_controller #(
        .CLK_FREQ(100), .SCAN_HZ(10), .NUM_DIGITS(8), .BLANK_CYCLES(2), .BLINK_HZ(1)
    ) u_dut8 (
        .clk(clk), .rst(rst), .i_mode(1'b0), .msec(ms8), .sec(s8), .min(m8),
        .hour(h8), .i_blink_mask(8'h00), .fnd_data(data8), .fnd_com(com8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // advance to the given posedge count since reset release, then sample 1 time unit later
    task automatic adv_to(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        exp4 = '{8'hF8, 8'hB0, 8'hA4, 8'h99,
                 8'hF8, 8'hB0, 8'hB0, 8'h99,
                 8'h92, 8'hC0, 8'h10, 8'hC0,
                 8'hF8, 8'hA4, 8'h30, 8'h99};
        exp8 = '{8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'h90, 8'h92, 8'hB0, 8'hA4,
                 8'h92, 8'h92, 8'h79, 8'hC0, 8'h10, 8'h92, 8'h30, 8'hA4};

        rst = 1'b1;
        mode4 = 1'b0; msec4 = 7'd37; sec4 = 6'd42; min4 = 6'd0; hour4 = 5'd0;
        ms8 = 7'd0; s8 = 6'd1; m8 = 6'd59; h8 = 5'd23;
        #1;
        check("rst_com4", 32'(com4), 32'h0000000F);
        check("rst_data4", 32'(data4), 32'h000000FF);
        check("rst_com8", 32'(com8), 32'h000000FF);
        check("rst_data8", 32'(data8), 32'h000000FF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;

        adv_to(10);
        check("prestart_com4", 32'(com4), 32'h0000000F);
        check("prestart_data4", 32'(data4), 32'h000000FF);

        for (int n = 0; n < 16; n++) begin
            adv_to(10 + 10 * n + 2);
            check($sformatf("blank_com4_%0d", n), 32'(com4), 32'h0000000F);
            check($sformatf("blank_com8_%0d", n), 32'(com8), 32'h000000FF);
            adv_to(10 + 10 * n + 3);
            e4 = ~(4'b0001 << (n % 4));
            e8 = ~(8'h01 << (n % 8));
            check($sformatf("com4_%0d", n), 32'(com4), 32'(e4));
            check($sformatf("data4_%0d", n), 32'(data4), 32'(exp4[n]));
            check($sformatf("com8_%0d", n), 32'(com8), 32'(e8));
            check($sformatf("data8_%0d", n), 32'(data8), 32'(exp8[n]));
            if (n == 1) begin
                sec4 = 6'd43;
                ms8  = 7'd55;
            end
            if (n == 5) begin
                mode4 = 1'b1; msec4 = 7'd75; min4 = 6'd5; hour4 = 5'd9;
            end
            if (n == 9) begin
                mode4 = 1'b0; msec4 = 7'd127;
            end
        end

        adv_to(edge_n + 2);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_com4", 32'(com4), 32'h0000000F);
        check("midrst_data4", 32'(data4), 32'h000000FF);
        check("midrst_com8", 32'(com8), 32'h000000FF);
        check("midrst_data8", 32'(data8), 32'h000000FF);
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
        adv_to(10);
        check("re_prestart_data4", 32'(data4), 32'h000000FF);
        check("re_prestart_com4", 32'(com4), 32'h0000000F);
        adv_to(12);
        check("re_blank_com4", 32'(com4), 32'h0000000F);
        adv_to(13);
        check("re_first_com4", 32'(com4), 32'h0000000E);
        check("re_first_data4", 32'(data4), 32'h000000F8);
        check("re_first_com8", 32'(com8), 32'h000000FE);
        check("re_first_data8", 32'(data8), 32'h00000092);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
